// File: rtl/risc5_pkg.sv
// Shared constants for the RV32 front end: default reset PC, canonical NOP,
// JumpFlag bit positions and a word-alignment helper.
package risc5_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    localparam int JF_JAL = 0;
    localparam int JF_BR  = 1;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// Two-entry FIFO with a registered head and synchronous clear; absorbs the
// one-cycle ROM latency so downstream stalls never drop a returned word.
module if_skid_buf
    import risc5_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [1:0]       count
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;

    always_comb begin
        count_d = count_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        if (clr) begin
            count_d = 2'd0;
        end else begin
            case ({enq, deq})
                2'b10: begin
                    if (count_q == 2'd0) ent0_d = enq_data;
                    else                 ent1_d = enq_data;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                // Dequeue and enqueue together: the queue shifts, depth is unchanged.
                2'b11: begin
                    if (count_q == 2'd2) begin
                        ent0_d = ent1_q;
                        ent1_d = enq_data;
                    end else begin
                        ent0_d = enq_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) count_q <= 2'd0;
        else        count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        ent0_q <= ent0_d;
        ent1_q <= ent1_d;
    end

    assign head  = ent0_q;
    assign valid = (count_q != 2'd0);
    assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC generation, synchronous ROM addressing,
// redirect handling and a skid buffer feeding the IF/ID register.
module if_fetch_unit
    import risc5_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = risc5_pkg::RESET_PC,
    parameter int          IMEM_AW   = 6,
    parameter logic [31:0] NOP_INSTR = risc5_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         JumpFlag,
    input  logic [31:0]        JumpAddr,
    input  logic               IFWrite,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        Instruction_if,
    output logic [31:0]        PC_if,
    output logic               if_valid,
    output logic               IF_flush
);

    logic        redirect, deq, enq, issue;
    logic [2:0]  occ;
    logic [31:0] issue_addr;
    logic [1:0]  buf_count;
    logic        buf_valid;
    logic [63:0] buf_head;

    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;

    always_comb begin
        redirect = JumpFlag[JF_JAL] | JumpFlag[JF_BR];
        deq      = IFWrite & buf_valid & ~redirect;
        enq      = inflight_q & ~redirect;
        // Occupancy after this cycle's dequeue; a new fetch only if its word will have a slot.
        occ      = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, deq};
        issue    = redirect | (occ < 3'd2);
        issue_addr    = redirect ? word_align(JumpAddr) : fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? issue_addr : inflight_pc_q;
        fetch_pc_d    = issue ? issue_addr + 32'd4 : fetch_pc_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        inflight_pc_q <= inflight_pc_d;
    end

    if_skid_buf #(
        .WIDTH (64)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .clr      (redirect),
        .enq      (enq),
        .enq_data ({inflight_pc_q, imem_rdata}),
        .deq      (deq),
        .head     (buf_head),
        .valid    (buf_valid),
        .count    (buf_count)
    );

    assign imem_addr      = issue_addr[IMEM_AW+1:2];
    assign IF_flush       = redirect;
    assign if_valid       = buf_valid;
    assign Instruction_if = buf_valid ? buf_head[31:0]  : NOP_INSTR;
    assign PC_if          = buf_valid ? buf_head[63:32] : 32'd0;

    // Buffered words plus the outstanding fetch can never exceed the two slots.
    a_occupancy : assert property (@(posedge clk) disable iff (!reset)
        (({1'b0, buf_count} + {2'b00, inflight_q}) <= 3'd2));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and randomized bench for if_fetch_unit against a stream-level model:
// the head PC advances by 4 per accepted word and restarts on reset or redirect.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  JumpFlag;
    logic [31:0] JumpAddr;
    logic        IFWrite;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction_if;
    logic [31:0] PC_if;
    logic        if_valid;
    logic        IF_flush;

    logic [31:0] rom [64];

    int          tests = 0;
    int          fails = 0;

    // Model state: expected head PC and rising edges since the last restart.
    logic [31:0] m_pc = 32'd0;
    int          since = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= rom[imem_addr];

    if_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_AW   (6),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .JumpFlag       (JumpFlag),
        .JumpAddr       (JumpAddr),
        .IFWrite        (IFWrite),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .Instruction_if (Instruction_if),
        .PC_if          (PC_if),
        .if_valid       (if_valid),
        .IF_flush       (IF_flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive on the falling edge, check, then advance the model.
    task automatic step(input logic rst_n, input logic [1:0] jf, input logic [31:0] ja,
                        input logic ifw);
        logic mv;
        logic [31:0] idx;
        @(negedge clk);
        reset    = rst_n;
        JumpFlag = jf;
        JumpAddr = ja;
        IFWrite  = ifw;
        #1;
        mv  = (since >= 2);
        idx = {26'd0, m_pc[7:2]};
        check("if_valid", {31'd0, if_valid}, {31'd0, mv});
        check("PC_if", PC_if, mv ? m_pc : 32'd0);
        check("Instruction_if", Instruction_if, mv ? rom[idx] : NOP);
        check("IF_flush", {31'd0, IF_flush}, {31'd0, (jf != 2'b00)});
        if (rst_n && jf != 2'b00)
            check("imem_addr_redirect", {26'd0, imem_addr}, {26'd0, ja[7:2]});
        @(posedge clk);
        if (!rst_n) begin
            since = 0;
            m_pc  = 32'd0;
        end else if (jf != 2'b00) begin
            // Target is fetched in the redirect cycle itself, one edge ahead of a reset restart.
            since = 1;
            m_pc  = ja & ~32'd3;
        end else begin
            if (mv && ifw) m_pc = m_pc + 32'd4;
            if (since < 2) since++;
        end
    endtask

    task automatic peek(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        #1;
        check("peek_valid", {31'd0, if_valid}, {31'd0, v});
        check("peek_pc", PC_if, pc);
        check("peek_instr", Instruction_if, ins);
    endtask

    task automatic peek_addr(input logic [5:0] a);
        check("stall_imem_addr", {26'd0, imem_addr}, {26'd0, a});
    endtask

    initial begin
        logic [1:0]  jf;
        logic [31:0] ja;
        for (int i = 0; i < 64; i++) rom[i] = 32'h1000 + i;
        reset    = 1'b0;
        JumpFlag = 2'b00;
        JumpAddr = 32'd0;
        IFWrite  = 1'b1;
        @(posedge clk);

        step(1'b0, 2'b00, 32'd0, 1'b1);
        peek(1'b0, 32'd0, NOP);
        step(1'b1, 2'b00, 32'd0, 1'b1);
        step(1'b1, 2'b00, 32'd0, 1'b1);
        peek(1'b1, 32'd0, 32'h1000);
        step(1'b1, 2'b00, 32'd0, 1'b1);
        peek(1'b1, 32'd4, 32'h1001);
        step(1'b1, 2'b00, 32'd0, 1'b1);
        peek(1'b1, 32'd8, 32'h1002);

        // Stall at PC 8: buffer holds 8,12 and the next fetch waits at 16.
        step(1'b1, 2'b00, 32'd0, 1'b0);
        peek(1'b1, 32'd8, 32'h1002);
        step(1'b1, 2'b00, 32'd0, 1'b0);
        peek(1'b1, 32'd8, 32'h1002);
        peek_addr(6'd4);
        step(1'b1, 2'b00, 32'd0, 1'b0);
        peek(1'b1, 32'd8, 32'h1002);
        peek_addr(6'd4);
        step(1'b1, 2'b00, 32'd0, 1'b1);
        peek(1'b1, 32'd12, 32'h1003);
        step(1'b1, 2'b00, 32'd0, 1'b1);
        peek(1'b1, 32'd16, 32'h1004);

        // Jump to 0x40.
        step(1'b1, 2'b01, 32'h40, 1'b1);
        peek(1'b0, 32'd0, NOP);
        step(1'b1, 2'b00, 32'd0, 1'b1);
        peek(1'b1, 32'h40, 32'h1010);
        step(1'b1, 2'b00, 32'd0, 1'b1);
        peek(1'b1, 32'h44, 32'h1011);

        // Branch while stalled with a full buffer.
        step(1'b1, 2'b00, 32'd0, 1'b0);
        step(1'b1, 2'b00, 32'd0, 1'b0);
        step(1'b1, 2'b10, 32'h23, 1'b0);
        peek(1'b0, 32'd0, NOP);
        step(1'b1, 2'b00, 32'd0, 1'b0);
        peek(1'b1, 32'h20, 32'h1008);
        step(1'b1, 2'b00, 32'd0, 1'b1);

        // Address wrap.
        step(1'b1, 2'b01, 32'hFFFF_FFFC, 1'b1);
        step(1'b1, 2'b00, 32'd0, 1'b1);
        peek(1'b1, 32'hFFFF_FFFC, 32'h103F);
        step(1'b1, 2'b00, 32'd0, 1'b1);
        peek(1'b1, 32'h0000_0000, 32'h1000);

        // Reset mid-operation with a stalled, filled buffer.
        step(1'b1, 2'b00, 32'd0, 1'b0);
        step(1'b1, 2'b00, 32'd0, 1'b0);
        step(1'b0, 2'b00, 32'd0, 1'b1);
        peek(1'b0, 32'd0, NOP);
        step(1'b1, 2'b00, 32'd0, 1'b1);
        peek(1'b0, 32'd0, NOP);
        step(1'b1, 2'b00, 32'd0, 1'b1);
        peek(1'b1, 32'd0, 32'h1000);

        // Randomized traffic with fresh ROM contents.
        step(1'b0, 2'b00, 32'd0, 1'b1);
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        step(1'b0, 2'b00, 32'd0, 1'b1);
        for (int n = 0; n < 500; n++) begin
            jf = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom);
            step(($urandom_range(0, 49) != 0), jf, ja, ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
